// File: rtl/alu_out_fifo.sv
// -----------------------------------------------------------------------------
// alu_out_fifo
// Elastic buffer placed directly after the fabric ALU data_out. It lets ALU
// results be produced at full rate while a slower consumer (reg_unit or the
// IO to_fabric path) drains them. Valid/ready handshake on both sides.
//
// Ports
//   clk        in   1                  single clock, rising edge
//   rst        in   1                  asynchronous active-high reset
//   flush      in   1                  synchronous clear of all entries
//   in_data    in   WIDTH              word from ALU data_out
//   in_valid   in   1                  in_data valid this cycle
//   in_ready   out  1                  FIFO accepts a word this cycle
//   out_data   out  WIDTH              head-of-queue word (0 when empty)
//   out_valid  out  1                  out_data valid
//   out_ready  in   1                  consumer takes out_data this cycle
//   count      out  $clog2(DEPTH+1)    entries currently held
//   overflow   out  1                  sticky: in_valid seen while full
// -----------------------------------------------------------------------------
module alu_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("alu_out_fifo: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the occupancy count alone; pointers are free to
    // wrap without an extra lap bit.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // in_ready deliberately ignores out_ready: a full FIFO never accepts a
    // word in the same cycle it is being popped.
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = ~w_empty & out_ready;

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;

    // Pointer and occupancy state; async reset makes the outputs above drop
    // to their idle values immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow survives flush; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && w_full && !flush) begin
            r_overflow <= 1'b1;
        end
    end

    // Storage is not reset; out_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_alu_out_fifo.sv
module tb_alu_out_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    count;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue of words plus the sticky overflow flag.
    logic [WIDTH-1:0] q[$];
    logic             m_ovf = 1'b0;

    alu_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_data;
        e_data = (q.size() != 0) ? q[0] : 32'h0;
        chk({tag, ".count"},     32'(count),     32'(q.size()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() != DEPTH));
        chk({tag, ".out_data"},  out_data,       e_data);
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    endtask

    // One clock of the reference behaviour, decided from the state before the edge.
    task automatic model_step(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        do_push = iv && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() > 0);
        if (fl) begin
            q.delete();
        end else begin
            if (iv && q.size() == DEPTH) m_ovf = 1'b1;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(id);
        end
    endtask

    task automatic step(input string tag, input logic iv, input logic [31:0] id,
                        input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        model_step(iv, id, ordy, fl);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset with in_valid held high
        in_valid = 1'b1;
        in_data  = 32'h77;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.out_data0", out_data, 32'h0);
        chk("reset.in_ready1", 32'(in_ready), 32'h1);
        rst = 1'b0;
        in_valid = 1'b0;

        // Ordering
        step("order.push", 1'b1, 32'h11, 1'b0, 1'b0);
        step("order.push", 1'b1, 32'h22, 1'b0, 1'b0);
        step("order.push", 1'b1, 32'h33, 1'b0, 1'b0);
        chk("order.count3", 32'(count), 32'd3);
        chk("order.head11", out_data, 32'h11);
        step("order.pop", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("order.head22", out_data, 32'h22);
        step("order.pop", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("order.head33", out_data, 32'h33);
        step("order.pop", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("order.empty", 32'(count), 32'd0);

        // Full and overflow
        for (int i = 0; i < 5; i++) begin
            step("full.push", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
            if (i == 3) chk("full.in_ready0", 32'(in_ready), 32'h0);
        end
        chk("full.overflow", 32'(overflow), 32'h1);
        chk("full.count4", 32'(count), 32'd4);
        step("full.pop_no_push", 1'b1, 32'hEE, 1'b1, 1'b0);
        chk("full.count3", 32'(count), 32'd3);
        chk("full.head_a1", out_data, 32'hA1);
        for (int i = 0; i < 3; i++) step("full.drain", 1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming through pointer wrap
        for (int i = 0; i < 20; i++) begin
            step("stream", 1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
            chk("stream.count1", 32'(count), 32'd1);
            chk("stream.data", out_data, 32'h100 + 32'(i));
        end

        // Flush with concurrent push and pop
        step("flush.fill", 1'b1, 32'hB1, 1'b0, 1'b0);
        step("flush.fill", 1'b1, 32'hB2, 1'b0, 1'b0);
        step("flush.do", 1'b1, 32'hB3, 1'b1, 1'b1);
        chk("flush.count0", 32'(count), 32'd0);
        chk("flush.ovf_kept", 32'(overflow), 32'h1);
        step("flush.push_aa", 1'b1, 32'hAA, 1'b0, 1'b0);
        chk("flush.first_aa", out_data, 32'hAA);
        step("flush.pop_aa", 1'b0, 32'h0, 1'b1, 1'b0);

        // Mid-operation asynchronous reset
        step("midrst.fill", 1'b1, 32'hC1, 1'b0, 1'b0);
        step("midrst.fill", 1'b1, 32'hC2, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_all("midrst.async");
        chk("midrst.out_data0", out_data, 32'h0);
        #1 rst = 1'b0;
        step("midrst.push55", 1'b1, 32'h55, 1'b0, 1'b0);
        step("midrst.pop", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("midrst.first55_gone", 32'(count), 32'd0);

        // Randomized traffic: a fill-heavy phase then a drain-heavy phase
        for (int i = 0; i < 400; i++) begin
            logic iv, ordy, fl;
            iv   = (i < 200) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
            ordy = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 39) == 0);
            step("rand", iv, $urandom, ordy, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
